store_drain_buffer: RTL and testbench

Store queue between the dual-lane memory stage and `data_mem`. Up to two committed stores per cycle enter a small FIFO; one store per cycle drains to `data_mem` write port 1, so the memory never sees two writes in a cycle. The block flags loads that overlap any pending store so the pipeline stalls until the store lands. `WE2` on `data_mem` is tied low; the block also frees `data_mem` from same-address write conflicts.

---
 rtl/riscv_mem_pkg.sv | 33 +++
 rtl/mem_overlap_chk.sv | 21 ++
 rtl/store_drain_buffer.sv | 145 ++++++++++++++
 tb/tb_store_drain_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared memory-stage definitions: funct3 encodings, access sizing and the store queue entry.
package riscv_mem_pkg;

  localparam int unsigned STORE_XLEN = 32;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Size in bytes; 0 marks an encoding that is not a legal access size.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      2'b10:   size = 3'd4;
      default: size = 3'd0;
    endcase
    return size;
  endfunction

  typedef struct packed {
    logic [STORE_XLEN-1:0] addr;
    logic [STORE_XLEN-1:0] data;
    logic [2:0]            funct3;
  } store_entry_t;

endpackage

// File: rtl/mem_overlap_chk.sv
// Combinational byte-range overlap test between two accesses [a, a+sa) and [b, b+sb).
module mem_overlap_chk #(
  parameter int unsigned ADDRESS_WIDTH = 17
) (
  input  logic [ADDRESS_WIDTH-1:0] a,
  input  logic [2:0]               sa,
  input  logic [ADDRESS_WIDTH-1:0] b,
  input  logic [2:0]               sb,
  output logic                     overlap
);

  logic [ADDRESS_WIDTH:0] a_ext, b_ext, a_end, b_end;

  // One extra bit keeps range ends from wrapping at the top of the address space.
  assign a_ext   = {1'b0, a};
  assign b_ext   = {1'b0, b};
  assign a_end   = a_ext + {{(ADDRESS_WIDTH - 2){1'b0}}, sa};
  assign b_end   = b_ext + {{(ADDRESS_WIDTH - 2){1'b0}}, sb};
  assign overlap = (a_ext < b_end) && (b_ext < a_end);

endmodule

// File: rtl/store_drain_buffer.sv
// Dual-entry store queue draining one store per cycle to data_mem port 1, with load hazard stalls.
module store_drain_buffer
  import riscv_mem_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ADDRESS_WIDTH = 17,
  parameter int unsigned DEPTH         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            st_valid1,
  input  logic            st_valid2,
  input  logic [XLEN-1:0] st_addr1,
  input  logic [XLEN-1:0] st_addr2,
  input  logic [XLEN-1:0] st_data1,
  input  logic [XLEN-1:0] st_data2,
  input  logic [2:0]      st_funct3_1,
  input  logic [2:0]      st_funct3_2,
  input  logic            ld_valid1,
  input  logic            ld_valid2,
  input  logic [XLEN-1:0] ld_addr1,
  input  logic [XLEN-1:0] ld_addr2,
  input  logic [2:0]      ld_funct3_1,
  input  logic [2:0]      ld_funct3_2,
  output logic            stall,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  output logic [2:0]      mem_funct3,
  output logic            empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  store_entry_t  fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_idx2;
  logic [CW-1:0] count_q, count_d, free_slots;

  logic [2:0] ld_sz1, ld_sz2, st_sz1, mem_sz;
  logic [DEPTH-1:0] ent_valid, hit1, hit2;
  logic mem_hit1, mem_hit2, lane_hit2;
  logic full_stall, ld_conflict1, ld_conflict2;
  logic push1, push2, pop;

  assign ld_sz1 = access_bytes(ld_funct3_1);
  assign ld_sz2 = access_bytes(ld_funct3_2);
  assign st_sz1 = access_bytes(st_funct3_1);
  assign mem_sz = access_bytes(mem_funct3);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] offs;
    logic [2:0]    ent_sz;
    assign offs         = PW'(i) - rd_ptr_q;
    assign ent_valid[i] = ({1'b0, offs} < count_q);
    assign ent_sz       = access_bytes(fifo_q[i].funct3);

    mem_overlap_chk #(.ADDRESS_WIDTH(AW)) u_chk1 (
      .a       (ld_addr1[AW-1:0]),
      .sa      (ld_sz1),
      .b       (fifo_q[i].addr[AW-1:0]),
      .sb      (ent_sz),
      .overlap (hit1[i])
    );

    mem_overlap_chk #(.ADDRESS_WIDTH(AW)) u_chk2 (
      .a       (ld_addr2[AW-1:0]),
      .sa      (ld_sz2),
      .b       (fifo_q[i].addr[AW-1:0]),
      .sb      (ent_sz),
      .overlap (hit2[i])
    );
  end

  mem_overlap_chk #(.ADDRESS_WIDTH(AW)) u_chk_mem1 (
    .a       (ld_addr1[AW-1:0]),
    .sa      (ld_sz1),
    .b       (mem_addr[AW-1:0]),
    .sb      (mem_sz),
    .overlap (mem_hit1)
  );

  mem_overlap_chk #(.ADDRESS_WIDTH(AW)) u_chk_mem2 (
    .a       (ld_addr2[AW-1:0]),
    .sa      (ld_sz2),
    .b       (mem_addr[AW-1:0]),
    .sb      (mem_sz),
    .overlap (mem_hit2)
  );

  // Younger lane-2 load against the older lane-1 store in the same bundle.
  mem_overlap_chk #(.ADDRESS_WIDTH(AW)) u_chk_lane (
    .a       (ld_addr2[AW-1:0]),
    .sa      (ld_sz2),
    .b       (st_addr1[AW-1:0]),
    .sb      (st_sz1),
    .overlap (lane_hit2)
  );

  assign free_slots   = DEPTH_C - count_q;
  assign full_stall   = free_slots < CW'(2);
  assign ld_conflict1 = ld_valid1 && (|(hit1 & ent_valid) || (mem_we && mem_hit1));
  assign ld_conflict2 = ld_valid2 && (|(hit2 & ent_valid) || (mem_we && mem_hit2) ||
                                      (st_valid1 && lane_hit2));
  assign stall        = full_stall | ld_conflict1 | ld_conflict2;

  assign push1   = !stall && st_valid1 && (st_sz1 != 3'd0);
  assign push2   = !stall && st_valid2 && (access_bytes(st_funct3_2) != 3'd0);
  assign pop     = (count_q != '0);
  assign wr_idx2 = push1 ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign count_d = count_q + CW'(push1) + CW'(push2) - CW'(pop);

  assign empty = (count_q == '0) && !mem_we;

  // Entry contents are don't-care after reset, so the storage itself carries no reset.
  always_ff @(posedge clk) begin
    if (push1) fifo_q[wr_ptr_q] <= '{addr: st_addr1, data: st_data1, funct3: st_funct3_1};
    if (push2) fifo_q[wr_idx2]  <= '{addr: st_addr2, data: st_data2, funct3: st_funct3_2};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      mem_funct3 <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_q + PW'(push1) + PW'(push2);
      mem_we   <= pop;
      if (pop) begin
        mem_addr   <= fifo_q[rd_ptr_q].addr;
        mem_wd     <= fifo_q[rd_ptr_q].data;
        mem_funct3 <= fifo_q[rd_ptr_q].funct3;
        rd_ptr_q   <= rd_ptr_q + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed self-checking bench for store_drain_buffer (DEPTH = 4).
module tb_store_drain_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid1, st_valid2;
  logic [31:0] st_addr1, st_addr2, st_data1, st_data2;
  logic [2:0]  st_funct3_1, st_funct3_2;
  logic        ld_valid1, ld_valid2;
  logic [31:0] ld_addr1, ld_addr2;
  logic [2:0]  ld_funct3_1, ld_funct3_2;
  logic        stall, mem_we, empty;
  logic [31:0] mem_addr, mem_wd;
  logic [2:0]  mem_funct3;

  int errors = 0;
  int checks = 0;

  store_drain_buffer #(.XLEN(32), .ADDRESS_WIDTH(17), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid1   (st_valid1),
    .st_valid2   (st_valid2),
    .st_addr1    (st_addr1),
    .st_addr2    (st_addr2),
    .st_data1    (st_data1),
    .st_data2    (st_data2),
    .st_funct3_1 (st_funct3_1),
    .st_funct3_2 (st_funct3_2),
    .ld_valid1   (ld_valid1),
    .ld_valid2   (ld_valid2),
    .ld_addr1    (ld_addr1),
    .ld_addr2    (ld_addr2),
    .ld_funct3_1 (ld_funct3_1),
    .ld_funct3_2 (ld_funct3_2),
    .stall       (stall),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_funct3  (mem_funct3),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    st_valid1 = 0; st_valid2 = 0; ld_valid1 = 0; ld_valid2 = 0;
    st_addr1 = 0; st_addr2 = 0; st_data1 = 0; st_data2 = 0;
    st_funct3_1 = 0; st_funct3_2 = 0;
    ld_addr1 = 0; ld_addr2 = 0; ld_funct3_1 = 0; ld_funct3_2 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if ({mem_we, mem_addr, mem_wd, mem_funct3} !== 68'd0) begin
      errors++; $display("FAIL reset_mem got we=%b a=%h d=%h f=%b exp all zero",
                         mem_we, mem_addr, mem_wd, mem_funct3);
    end
    tick();
    rst_n = 1;
  endtask

  task automatic test_single_sw();
    st_valid1 = 1; st_addr1 = 32'h100; st_data1 = 32'hDEADBEEF; st_funct3_1 = 3'b010;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sw_accept_stall got=%b exp=0", stall); end
    tick();
    clear_inputs();
    checks++; if (mem_we !== 1'b0 || empty !== 1'b0) begin
      errors++; $display("FAIL sw_queued got we=%b empty=%b exp we=0 empty=0", mem_we, empty);
    end
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wd !== 32'hDEADBEEF ||
                  mem_funct3 !== 3'b010) begin
      errors++; $display("FAIL sw_drain got we=%b a=%h d=%h f=%b exp 1 100 deadbeef 010",
                         mem_we, mem_addr, mem_wd, mem_funct3);
    end
    tick();
    checks++; if (mem_we !== 1'b0 || empty !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL sw_idle got we=%b empty=%b a=%h exp 0 1 100", mem_we, empty, mem_addr);
    end
  endtask

  task automatic test_dual_sb();
    logic [7:0] last_byte;
    last_byte = 8'h00;
    st_valid1 = 1; st_addr1 = 32'h10; st_data1 = 32'h11; st_funct3_1 = 3'b000;
    st_valid2 = 1; st_addr2 = 32'h10; st_data2 = 32'h22; st_funct3_2 = 3'b000;
    tick();
    clear_inputs();
    tick();
    if (mem_we) last_byte = mem_wd[7:0];
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wd !== 32'h11) begin
      errors++; $display("FAIL dual_first got we=%b a=%h d=%h exp 1 10 11", mem_we, mem_addr, mem_wd);
    end
    tick();
    if (mem_we) last_byte = mem_wd[7:0];
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wd !== 32'h22) begin
      errors++; $display("FAIL dual_second got we=%b a=%h d=%h exp 1 10 22", mem_we, mem_addr, mem_wd);
    end
    tick();
    checks++; if (last_byte !== 8'h22 || mem_we !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL dual_final got byte=%h we=%b empty=%b exp 22 0 1",
                         last_byte, mem_we, empty);
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_addr [6];
    logic [31:0] exp_data [6];
    exp_addr = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h310, 32'h314};
    exp_data = '{32'hA1, 32'hA2, 32'hB1, 32'hB2, 32'hC1, 32'hC2};
    st_funct3_1 = 3'b010; st_funct3_2 = 3'b010; st_valid1 = 1; st_valid2 = 1;
    st_addr1 = exp_addr[0]; st_data1 = exp_data[0]; st_addr2 = exp_addr[1]; st_data2 = exp_data[1];
    tick();
    checks++; if (mem_we !== 1'b0 || empty !== 1'b0) begin
      errors++; $display("FAIL fill_e1 got we=%b empty=%b exp 0 0", mem_we, empty);
    end
    st_addr1 = exp_addr[2]; st_data1 = exp_data[2]; st_addr2 = exp_addr[3]; st_data2 = exp_data[3];
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_count2_stall got=%b exp=0", stall); end
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== exp_addr[0] || mem_wd !== exp_data[0]) begin
      errors++; $display("FAIL fill_w0 got we=%b a=%h d=%h exp 1 %h %h",
                         mem_we, mem_addr, mem_wd, exp_addr[0], exp_data[0]);
    end
    st_addr1 = exp_addr[4]; st_data1 = exp_data[4]; st_addr2 = exp_addr[5]; st_data2 = exp_data[5];
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fill_count3_stall got=%b exp=1", stall); end
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== exp_addr[1] || mem_wd !== exp_data[1]) begin
      errors++; $display("FAIL fill_w1 got we=%b a=%h d=%h exp 1 %h %h",
                         mem_we, mem_addr, mem_wd, exp_addr[1], exp_data[1]);
    end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_resume_stall got=%b exp=0", stall); end
    tick();
    clear_inputs();
    for (int k = 2; k < 6; k++) begin
      checks++; if (mem_we !== 1'b1 || mem_addr !== exp_addr[k] || mem_wd !== exp_data[k]) begin
        errors++; $display("FAIL fill_w%0d got we=%b a=%h d=%h exp 1 %h %h",
                           k, mem_we, mem_addr, mem_wd, exp_addr[k], exp_data[k]);
      end
      tick();
    end
    checks++; if (mem_we !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL fill_done got we=%b empty=%b exp 0 1", mem_we, empty);
    end
  endtask

  task automatic test_overlap();
    st_valid1 = 1; st_addr1 = 32'h200; st_data1 = 32'h55; st_funct3_1 = 3'b010;
    tick();
    clear_inputs();
    ld_valid1 = 1; ld_addr1 = 32'h203; ld_funct3_1 = 3'b000;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ovl_fifo_stall got=%b exp=1", stall); end
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h200 || stall !== 1'b1) begin
      errors++; $display("FAIL ovl_outreg got we=%b a=%h stall=%b exp 1 200 1", mem_we, mem_addr, stall);
    end
    tick();
    checks++; if (mem_we !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL ovl_release got we=%b stall=%b exp 0 0", mem_we, stall);
    end
    clear_inputs();
    st_valid1 = 1; st_addr1 = 32'h200; st_data1 = 32'h66; st_funct3_1 = 3'b010;
    tick();
    clear_inputs();
    ld_valid1 = 1; ld_addr1 = 32'h204; ld_funct3_1 = 3'b000;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ovl_adjacent got=%b exp=0", stall); end
    tick();
    ld_valid2 = 1; ld_addr2 = 32'h202; ld_funct3_2 = 3'b001;
    #1;
    checks++; if (mem_we !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL ovl_lane2_outreg got we=%b stall=%b exp 1 1", mem_we, stall);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_same_cycle();
    st_valid1 = 1; st_addr1 = 32'h40; st_data1 = 32'h1234; st_funct3_1 = 3'b001;
    ld_valid2 = 1; ld_addr2 = 32'h41; ld_funct3_2 = 3'b101;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL same_sh_lhu got=%b exp=1", stall); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL same_held got empty=%b exp=1", empty); end
    clear_inputs();
    ld_valid1 = 1; ld_addr1 = 32'h40; ld_funct3_1 = 3'b010;
    st_valid2 = 1; st_addr2 = 32'h40; st_data2 = 32'hCAFE0001; st_funct3_2 = 3'b010;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_lw_sw got=%b exp=0", stall); end
    tick();
    clear_inputs();
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wd !== 32'hCAFE0001) begin
      errors++; $display("FAIL same_lane2_only got we=%b a=%h d=%h exp 1 40 cafe0001",
                         mem_we, mem_addr, mem_wd);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    st_valid1 = 1; st_valid2 = 1; st_funct3_1 = 3'b010; st_funct3_2 = 3'b010;
    st_addr1 = 32'h500; st_data1 = 32'h1; st_addr2 = 32'h504; st_data2 = 32'h2;
    tick();
    st_addr1 = 32'h508; st_data1 = 32'h3; st_addr2 = 32'h50C; st_data2 = 32'h4;
    tick();
    clear_inputs();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h500) begin
      errors++; $display("FAIL rstmid_pre got we=%b a=%h exp 1 500", mem_we, mem_addr);
    end
    rst_n = 0;
    #1;
    checks++; if (mem_we !== 1'b0 || empty !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL rstmid_now got we=%b empty=%b stall=%b exp 0 1 0", mem_we, empty, stall);
    end
    tick();
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (mem_we !== 1'b0 || empty !== 1'b1) begin
        errors++; $display("FAIL rstmid_after%0d got we=%b empty=%b exp 0 1", k, mem_we, empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_sw();
    test_dual_sb();
    test_fill();
    test_overlap();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
